// File: rtl/ff_input_pkg.sv
// Shared constants and types for the input controller: PS/2 key codes,
// sw bit positions, the coin FSM state encoding and the analog axis mapping.
package ff_input_pkg;

   // Direction keys match on the low byte only, so arrow and keypad keys both work
   localparam logic [7:0] KEY_UP    = 8'h75;
   localparam logic [7:0] KEY_DOWN  = 8'h72;
   localparam logic [7:0] KEY_LEFT  = 8'h6B;
   localparam logic [7:0] KEY_RIGHT = 8'h74;

   // Remaining keys match on the full 9-bit code, including the extended bit
   localparam logic [8:0] KEY_SPACE = 9'h029;
   localparam logic [8:0] KEY_LCTRL = 9'h014;
   localparam logic [8:0] KEY_F1    = 9'h005;
   localparam logic [8:0] KEY_F2    = 9'h006;
   localparam logic [8:0] KEY_5     = 9'h02E;
   localparam logic [8:0] KEY_F4    = 9'h00C;

   // Bit positions within the active-low sw bus
   localparam int unsigned SW_JS_D   = 11;
   localparam int unsigned SW_JS_U   = 10;
   localparam int unsigned SW_JS_L   = 9;
   localparam int unsigned SW_JS_R   = 8;
   localparam int unsigned SW_COIN1  = 7;
   localparam int unsigned SW_COIN2  = 6;
   localparam int unsigned SW_START1 = 5;
   localparam int unsigned SW_START2 = 4;
   localparam int unsigned SW_COINAUX = 3;
   localparam int unsigned SW_THROW1 = 2;
   localparam int unsigned SW_THROW2 = 1;
   localparam int unsigned SW_TEST   = 0;

   typedef enum logic [1:0] {
      COIN_IDLE,
      COIN_PULSE,
      COIN_HOLDOFF
   } coin_state_t;

   // Active-high control flags, one per logical input
   typedef struct packed {
      logic up;
      logic down;
      logic left;
      logic right;
      logic throw1;
      logic start1;
      logic start2;
      logic coin;
      logic test;
   } ctrl_t;

   // Signed axis to unsigned 0x00..0xFF with centre 0x7F; small deflections snap to centre.
   // Two's-complement magnitude of 0x80 wraps to 0x80, i.e. 128, which is what we want.
   function automatic logic [7:0] axis_map(input logic [7:0] v, input logic [7:0] dz);
      logic [7:0] mag;
      mag = v[7] ? (~v + 8'd1) : v;
      return (mag <= dz) ? 8'h7F : (v ^ 8'h7F);
   endfunction

endpackage

// File: rtl/ff_coin_pulser.sv
// Converts a coin request level into a single fixed-width active-low coin pulse
// followed by a hold-off window in which further requests are dropped.
module ff_coin_pulser
   import ff_input_pkg::*;
#(
   parameter int unsigned COIN_PULSE_CYC   = 2500000,
   parameter int unsigned COIN_HOLDOFF_CYC = 5000000
) (
   input  logic clk_sys,
   input  logic reset,
   input  logic req,
   output logic coin_n,
   output logic busy
);

   localparam int unsigned CNT_MAX = (COIN_PULSE_CYC > COIN_HOLDOFF_CYC) ? COIN_PULSE_CYC : COIN_HOLDOFF_CYC;
   localparam int unsigned CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CW-1:0] PULSE_LAST   = CW'(COIN_PULSE_CYC - 1);
   localparam logic [CW-1:0] HOLDOFF_LAST = CW'(COIN_HOLDOFF_CYC - 1);

   coin_state_t   state;
   logic [CW-1:0] cnt;
   logic          req_q;
   logic          req_rise;

   // Rising edge of the request level
   always_comb begin
      req_rise = req & ~req_q;
   end

   // Coin FSM; req_q tracks req even in reset so a held request cannot fire on release
   always_ff @(posedge clk_sys) begin
      req_q <= req;
      if (reset) begin
         state  <= COIN_IDLE;
         cnt    <= '0;
         coin_n <= 1'b1;
         busy   <= 1'b0;
      end else begin
         case (state)
            COIN_IDLE: begin
               if (req_rise) begin
                  state  <= COIN_PULSE;
                  cnt    <= '0;
                  coin_n <= 1'b0;
                  busy   <= 1'b1;
               end
            end
            COIN_PULSE: begin
               if (cnt == PULSE_LAST) begin
                  state  <= COIN_HOLDOFF;
                  cnt    <= '0;
                  coin_n <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            COIN_HOLDOFF: begin
               if (cnt == HOLDOFF_LAST) begin
                  state <= COIN_IDLE;
                  cnt   <= '0;
                  busy  <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state  <= COIN_IDLE;
               cnt    <= '0;
               coin_n <= 1'b1;
               busy   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/ff_input_ctrl.sv
// Merges PS/2 keyboard and digital joysticks into the active-low cabinet switch
// bus, generates timed coin pulses from start/coin presses, and rescales the
// analog stick to the cabinet's unsigned centre-0x7F convention.
module ff_input_ctrl
   import ff_input_pkg::*;
#(
   parameter int unsigned COIN_PULSE_CYC   = 2500000,
   parameter int unsigned COIN_HOLDOFF_CYC = 5000000,
   parameter int unsigned DEADZONE         = 8
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic [10:0] ps2_key,
   input  logic [15:0] joystick_0,
   input  logic [15:0] joystick_1,
   input  logic [15:0] joystick_analog_0,
   output logic [11:0] sw,
   output logic [15:0] js_analog,
   output logic        coin_busy
);

   logic        tog_q;
   logic        key_evt;
   ctrl_t       held;
   ctrl_t       act;
   logic [15:0] joy;
   logic        coin_req;
   logic        coin_n;
   logic [11:0] sw_next;
   logic        unused_joy_hi;

   // Combine keyboard flags with both joysticks and assemble the next sw word
   always_comb begin
      joy           = joystick_0 | joystick_1;
      unused_joy_hi = ^joy[15:8];
      key_evt       = ps2_key[10] ^ tog_q;

      act.right  = held.right  | joy[0];
      act.left   = held.left   | joy[1];
      act.down   = held.down   | joy[2];
      act.up     = held.up     | joy[3];
      act.throw1 = held.throw1 | joy[4];
      act.start1 = held.start1 | joy[5];
      act.start2 = held.start2 | joy[6];
      act.coin   = held.coin   | joy[7];
      act.test   = held.test;

      coin_req = act.start1 | act.start2 | act.coin;

      sw_next             = '1;
      sw_next[SW_JS_D]    = ~act.down;
      sw_next[SW_JS_U]    = ~act.up;
      sw_next[SW_JS_L]    = ~act.left;
      sw_next[SW_JS_R]    = ~act.right;
      sw_next[SW_COIN1]   = coin_n;
      sw_next[SW_START1]  = ~act.start1;
      sw_next[SW_START2]  = ~act.start2;
      sw_next[SW_THROW1]  = ~act.throw1;
      sw_next[SW_TEST]    = ~act.test;
   end

   // PS/2 decode: each toggle of bit 10 updates one held flag with the press state
   always_ff @(posedge clk_sys) begin
      tog_q <= ps2_key[10];
      if (reset) begin
         held <= '0;
      end else if (key_evt) begin
         case (ps2_key[7:0])
            KEY_UP:    held.up    <= ps2_key[9];
            KEY_DOWN:  held.down  <= ps2_key[9];
            KEY_LEFT:  held.left  <= ps2_key[9];
            KEY_RIGHT: held.right <= ps2_key[9];
            default: ;
         endcase
         case (ps2_key[8:0])
            KEY_SPACE, KEY_LCTRL: held.throw1 <= ps2_key[9];
            KEY_F1:               held.start1 <= ps2_key[9];
            KEY_F2:               held.start2 <= ps2_key[9];
            KEY_5:                held.coin   <= ps2_key[9];
            KEY_F4:               held.test   <= ps2_key[9];
            default: ;
         endcase
      end
   end

   // Registered switch and analog outputs
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         sw        <= '1;
         js_analog <= 16'h7F7F;
      end else begin
         sw        <= sw_next;
         js_analog <= {axis_map(joystick_analog_0[15:8], 8'(DEADZONE)),
                       axis_map(joystick_analog_0[7:0],  8'(DEADZONE))};
      end
   end

   ff_coin_pulser #(
      .COIN_PULSE_CYC   (COIN_PULSE_CYC),
      .COIN_HOLDOFF_CYC (COIN_HOLDOFF_CYC)
   ) u_coin (
      .clk_sys (clk_sys),
      .reset   (reset),
      .req     (coin_req),
      .coin_n  (coin_n),
      .busy    (coin_busy)
   );

endmodule

// File: tb/tb_ff_input_ctrl.sv
// Directed bench for ff_input_ctrl: expectations are queued with a due cycle
// as stimulus is driven and checked on the falling edge of that cycle.
module tb_ff_input_ctrl;

  localparam int SEL_SW   = 0;
  localparam int SEL_JS   = 1;
  localparam int SEL_BUSY = 2;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic [15:0] joystick_0;
  logic [15:0] joystick_1;
  logic [15:0] joystick_analog_0;
  logic [11:0] sw;
  logic [15:0] js_analog;
  logic        coin_busy;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string       tag;
    int          due;
    int          sel;
    logic [15:0] mask;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];

  logic [15:0] an_in  [9] = '{16'h0000, 16'h007F, 16'h0080, 16'h0005, 16'hF000,
                              16'h00F8, 16'h0009, 16'h00F7, 16'h807F};
  logic [15:0] an_exp [9] = '{16'h7F7F, 16'h7F00, 16'h7FFF, 16'h7F7F, 16'h8F7F,
                              16'h7F7F, 16'h7F76, 16'h7F88, 16'hFF00};

  ff_input_ctrl #(
    .COIN_PULSE_CYC   (4),
    .COIN_HOLDOFF_CYC (8),
    .DEADZONE         (8)
  ) dut (
    .clk_sys           (clk_sys),
    .reset             (reset),
    .ps2_key           (ps2_key),
    .joystick_0        (joystick_0),
    .joystick_1        (joystick_1),
    .joystick_analog_0 (joystick_analog_0),
    .sw                (sw),
    .js_analog         (js_analog),
    .coin_busy         (coin_busy)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) cyc <= cyc + 1;

  function automatic logic [15:0] observe(input int sel);
    case (sel)
      SEL_SW:  return {4'h0, sw};
      SEL_JS:  return js_analog;
      default: return {15'h0, coin_busy};
    endcase
  endfunction

  int          chk_i;
  logic [15:0] chk_obs;

  // Scoreboard drain: compare every entry whose due cycle has arrived
  always @(negedge clk_sys) begin
    chk_i = 0;
    while (chk_i < sb.size()) begin
      if (sb[chk_i].due <= cyc) begin
        chk_obs = observe(sb[chk_i].sel) & sb[chk_i].mask;
        vectors++;
        assert (sb[chk_i].due == cyc && chk_obs === sb[chk_i].val) else begin
          miscompares++;
          $display("FAIL %s cyc=%0d: observed %h expected %h", sb[chk_i].tag, cyc, chk_obs, sb[chk_i].val);
          $error("miscompare on %s", sb[chk_i].tag);
        end
        sb.delete(chk_i);
      end else begin
        chk_i++;
      end
    end
  end

  task automatic push_exp(input string tag, input int delay, input int sel,
                          input logic [15:0] mask, input logic [15:0] val);
    exp_t e;
    e.tag  = tag;
    e.due  = cyc + delay;
    e.sel  = sel;
    e.mask = mask;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic key(input logic [8:0] code, input logic pressed);
    ps2_key = {~ps2_key[10], pressed, code};
  endtask

  // One coin pulse starting from a request rising now: sw[7] low on d=2..5, busy on d=1..12
  task automatic coin_exp(input string tag);
    for (int d = 1; d <= 7; d++)
      push_exp($sformatf("%s_sw7_d%0d", tag, d), d, SEL_SW, 16'h0080,
               (d >= 2 && d <= 5) ? 16'h0000 : 16'h0080);
    for (int d = 0; d <= 14; d++)
      push_exp($sformatf("%s_busy_d%0d", tag, d), d, SEL_BUSY, 16'h0001,
               (d >= 1 && d <= 12) ? 16'h0001 : 16'h0000);
  endtask

  initial begin
    reset             = 1'b1;
    ps2_key           = 11'h000;
    joystick_0        = 16'h0000;
    joystick_1        = 16'h0000;
    joystick_analog_0 = 16'h0000;

    // Reset state; a toggle during reset must not become an event afterwards
    tick();
    vectors++;
    if (sw !== 12'hFFF || js_analog !== 16'h7F7F || coin_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: sw=%h js=%h busy=%b", sw, js_analog, coin_busy);
      $error("reset state mismatch");
    end
    ps2_key = 11'h675;
    tick();
    push_exp("rst_sw",   0, SEL_SW,   16'h0FFF, 16'h0FFF);
    push_exp("rst_js",   0, SEL_JS,   16'hFFFF, 16'h7F7F);
    push_exp("rst_busy", 0, SEL_BUSY, 16'h0001, 16'h0000);
    reset = 1'b0;
    tick(3);
    push_exp("no_spurious", 0, SEL_SW, 16'h0FFF, 16'h0FFF);

    // Up pressed then released, two-cycle latency
    key(9'h175, 1'b1);
    push_exp("up_press_d1", 1, SEL_SW, 16'h0F00, 16'h0F00);
    push_exp("up_press_d2", 2, SEL_SW, 16'h0F00, 16'h0B00);
    tick(3);
    key(9'h175, 1'b0);
    push_exp("up_rel_d1", 1, SEL_SW, 16'h0F00, 16'h0B00);
    push_exp("up_rel_d2", 2, SEL_SW, 16'h0F00, 16'h0F00);
    tick(3);

    // Down without extended bit
    key(9'h072, 1'b1);
    push_exp("down_press", 2, SEL_SW, 16'h0F00, 16'h0700);
    tick(3);
    key(9'h072, 1'b0);
    push_exp("down_rel", 2, SEL_SW, 16'h0F00, 16'h0F00);
    tick(3);

    // Test key
    key(9'h00C, 1'b1);
    push_exp("test_press", 2, SEL_SW, 16'h0001, 16'h0000);
    tick(3);
    key(9'h00C, 1'b0);
    push_exp("test_rel", 2, SEL_SW, 16'h0001, 16'h0001);
    tick(3);

    // Throw from second joystick
    joystick_1 = 16'h0010;
    push_exp("throw_js1", 1, SEL_SW, 16'h0004, 16'h0000);
    tick(2);
    joystick_1 = 16'h0000;
    push_exp("throw_js1_rel", 1, SEL_SW, 16'h0004, 16'h0004);
    tick(2);

    // Unmapped code leaves sw untouched
    key(9'h01C, 1'b1);
    push_exp("unmapped_d2", 2, SEL_SW, 16'h0FFF, 16'h0FFF);
    push_exp("unmapped_d3", 3, SEL_SW, 16'h0FFF, 16'h0FFF);
    tick(4);

    // F1 press and release on consecutive cycles
    key(9'h005, 1'b1);
    push_exp("dup_d2", 2, SEL_SW, 16'h0020, 16'h0000);
    push_exp("dup_d3", 3, SEL_SW, 16'h0020, 16'h0020);
    push_exp("dup_d5", 5, SEL_SW, 16'h0020, 16'h0020);
    tick();
    key(9'h005, 1'b0);
    tick(20);

    // Coin timing from joystick start1; start1 still visible during the pulse
    joystick_0 = 16'h0020;
    coin_exp("coin");
    for (int d = 1; d <= 7; d++)
      push_exp($sformatf("coin_st1_d%0d", d), d, SEL_SW, 16'h0020, 16'h0000);
    tick(16);
    joystick_0 = 16'h0000;
    tick(2);

    // Lockout: start2 during PULSE is dropped, re-press after HOLDOFF fires again
    joystick_0 = 16'h0080;
    coin_exp("lock1");
    for (int d = 8; d <= 18; d++)
      push_exp($sformatf("lock1_sw7_d%0d", d), d, SEL_SW, 16'h0080, 16'h0080);
    for (int d = 15; d <= 18; d++)
      push_exp($sformatf("lock1_busy_d%0d", d), d, SEL_BUSY, 16'h0001, 16'h0000);
    tick();
    joystick_0 = 16'h0000;
    tick();
    joystick_0 = 16'h0040;
    tick(16);
    joystick_0 = 16'h0000;
    tick(2);
    joystick_0 = 16'h0040;
    coin_exp("lock2");
    tick(16);
    joystick_0 = 16'h0000;
    tick(2);

    // Start1 and start2 rising together give one pulse
    joystick_0 = 16'h0060;
    coin_exp("both");
    for (int d = 8; d <= 16; d++)
      push_exp($sformatf("both_sw7_d%0d", d), d, SEL_SW, 16'h0080, 16'h0080);
    tick(16);
    joystick_0 = 16'h0000;
    tick(2);

    // Reset on pulse cycle 2; held request must not fire after release
    joystick_0 = 16'h0020;
    push_exp("rmid_sw7_low", 2, SEL_SW, 16'h0080, 16'h0000);
    push_exp("rmid_sw_fff",  3, SEL_SW, 16'h0FFF, 16'h0FFF);
    for (int d = 3; d <= 12; d++)
      push_exp($sformatf("rmid_busy_d%0d", d), d, SEL_BUSY, 16'h0001, 16'h0000);
    for (int d = 5; d <= 12; d++)
      push_exp($sformatf("rmid_sw_d%0d", d), d, SEL_SW, 16'h00A0, 16'h0080);
    tick(2);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(10);
    joystick_0 = 16'h0000;
    tick(2);

    // Analog mapping and deadzone boundaries
    for (int i = 0; i < 9; i++) begin
      joystick_analog_0 = an_in[i];
      push_exp($sformatf("analog_%h", an_in[i]), 1, SEL_JS, 16'hFFFF, an_exp[i]);
      tick();
    end
    tick(3);

    vectors++;
    if (sb.size() != 0) begin
      miscompares += sb.size();
      $display("FAIL expired_wait: %0d expectations never checked", sb.size());
      $error("scoreboard not drained");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ff_input_ctrl.md
FF_INPUT_CTRL -- requirements
Module: ff_input_ctrl

Interface
REQ-001 SHALL have parameter COIN_PULSE_CYC, default 2500000: number of clk_sys cycles the coin1 switch is held asserted per coin (100 ms at 25 MHz).
REQ-002 SHALL have parameter COIN_HOLDOFF_CYC, default 5000000: number of clk_sys cycles after a pulse during which new coin requests are ignored.
REQ-003 SHALL have parameter DEADZONE, default 8: analog magnitude at or below which an axis reads as centre.
REQ-004 SHALL have port clk_sys  in  1: the single clock.
REQ-005 SHALL have port reset  in  1: synchronous, active-high reset.
REQ-006 SHALL have port ps2_key  in  11: bit [10] toggle (event marker), bit [9] pressed, bits [8:0] code with bit 8 = extended.
REQ-007 SHALL have ports joystick_0 and joystick_1  in  16 each, active-high; bit 0 right, 1 left, 2 down, 3 up, 4 throw, 5 start1, 6 start2, 7 coin.
REQ-008 SHALL have port joystick_analog_0  in  16: signed X in [7:0], signed Y in [15:8].
REQ-009 SHALL have port sw  out  12, active-low: {js_d, js_u, js_l, js_r, coin1, coin2, start1, start2, coinaux, throw1, throw2, test}.
REQ-010 SHALL have port js_analog  out  16: {y, x}, unsigned; 0x00 = right/down, 0x7F = centre, 0xFF = left/up.
REQ-011 SHALL have port coin_busy  out  1: high while the coin FSM is not IDLE.

Function
REQ-012 SHALL detect a key event when ps2_key[10] differs from its value registered on the previous cycle.
REQ-013 SHALL map key events as follows, setting each held flag to ps2_key[9] on its event:
- codes 0x75 / 0x72 / 0x6B / 0x74 (extended bit ignored): up / down / left / right
- 0x029 or 0x014: throw
- 0x005: start1
- 0x006: start2
- 0x02E: coin
- 0x00C: test
- all other codes: ignored
REQ-014 SHALL OR each held flag with the matching bit of (joystick_0 | joystick_1); test has no joystick source.
REQ-015 SHALL make sw a registered output; a key event SHALL be visible on sw exactly 2 clk_sys cycles after the toggle change.
REQ-016 SHALL drive coin2, coinaux and throw2 permanently high (inactive).
REQ-017 SHALL form the coin request as start1 | start2 | coin and start the coin FSM only on a rising edge of that request.
REQ-018 Coin FSM SHALL have three states:
- IDLE: a rising edge moves to PULSE.
- PULSE: coin1 is held low for exactly COIN_PULSE_CYC cycles, then move to HOLDOFF.
- HOLDOFF: coin1 is high for COIN_HOLDOFF_CYC cycles, then move to IDLE.
REQ-019 SHALL discard coin requests arriving in PULSE or HOLDOFF, with no queuing.
REQ-020 Simultaneous start1 and start2 rising in the same cycle SHALL produce exactly one pulse.
REQ-021 Start1 and start2 SHALL still pass through to their own sw bits while a coin pulse is in progress.
REQ-022 SHALL compute each analog axis as v XOR 0x7F (equivalent to 255 - (v + 128)).
REQ-023 SHALL force an axis output to 0x7F when the signed |v| <= DEADZONE; v = -128 has magnitude 128.
REQ-024 SHALL register js_analog with 1-cycle latency.

Reset
REQ-025 On reset, all held flags SHALL clear, sw SHALL be 12'hFFF, js_analog SHALL be 16'h7F7F, the FSM SHALL go to IDLE, the counters SHALL be 0, and coin_busy SHALL be 0.
REQ-026 During reset, the previous-toggle register SHALL load ps2_key[10] so that no spurious event occurs on release.
REQ-027 Reset asserted mid-PULSE SHALL return coin1 high on the next cycle; a request still held at release SHALL not start a pulse until it has fallen and risen again.

Structure
REQ-028 Package ff_input_pkg SHALL hold the key-code constants, the sw bit-index constants and the coin FSM state enum.
REQ-029 The coin FSM and its counter SHALL be a sub-module ff_coin_pulser, with ports clk_sys, reset, req, coin_n and busy, and both cycle counts as parameters.

Verification (bench parameters: COIN_PULSE_CYC=4, COIN_HOLDOFF_CYC=8)
REQ-030 Bench SHALL cover key press then release:
- toggle ps2_key with 0x175 pressed -> sw[11:8]=4'b1011 two cycles later
- toggle with 0x175 released -> sw[11:8]=4'hF
REQ-031 Bench SHALL cover coin timing: joystick_0[5] rises -> sw[7] low for exactly 4 cycles, coin_busy high for 12 cycles.
REQ-032 Bench SHALL cover coin lockout:
- start2 pressed 2 cycles into PULSE -> no second pulse
- start2 released and re-pressed after HOLDOFF -> second pulse of 4 cycles
REQ-033 Bench SHALL cover the analog mapping:
- x=0x00 -> 0x7F; x=0x7F -> 0x00; x=0x80 -> 0xFF
- x=0x05 -> 0x7F (deadzone); y=0xF0 -> 0x8F
REQ-034 Bench SHALL cover reset mid-PULSE: reset on pulse cycle 2 -> sw=12'hFFF next cycle, no pulse on release while the request is still held.
REQ-035 Bench SHALL cover unmapped and duplicate events:
- code 0x01C event -> sw unchanged
- two toggles on consecutive cycles, F1 pressed then F1 released -> start1 ends high
